dht_report: RTL and testbench
=============================

# dht_report

Downstream consumer of the DHT11 reader. Takes each completed 40-bit reading (humidity int/frac, temperature int/frac, checksum byte), verifies the checksum, and keeps the last good reading on parallel outputs. Emits a fixed 6-byte status frame per reading on a UART TX line for the host microcontroller.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 868 at defaults)
- STALE_LIMIT, 3, consecutive bad readings before the stale flag sets

Ports:
- CLK  input  1  system clock, 100 MHz
- RST  input  1  reset, asynchronous, active-low
- DHT_valid  input  1  one-cycle pulse: reading inputs are stable this cycle
- DHT_error  input  1  reader timeout/protocol error, sampled with DHT_valid
- hum_int, hum_float, tmp_int, tmp_float, parity  input  8 each  reading bytes from the reader
- good_hum_int, good_hum_float, good_tmp_int, good_tmp_float  output  8 each  last reading that passed the check
- good_seen  output  1  at least one good reading since reset
- stale  output  1  fail_cnt >= STALE_LIMIT
- fail_cnt  output  4  consecutive bad readings, saturates at 15
- TX  output  1  UART line, idle high
- busy  output  1  frame in progress

## Operation
- Check: sum8 = (hum_int + hum_float + tmp_int + tmp_float) mod 256. Reading is good iff sum8 == parity and DHT_error == 0.
- Good reading: copy the four bytes to the good_* registers, set good_seen, clear fail_cnt.
- Bad reading: good_* registers unchanged. fail_cnt increments and saturates at 15.
- Frame bytes, in order: 0xA5, good_hum_int, good_hum_float, good_tmp_int, good_tmp_float, status. The data bytes are always the last-good values, read after the update.
- Status byte bits:
  - bit0: checksum mismatch
  - bit1: DHT_error
  - bit2: stale
  - bit3: overrun
  - bit4: good_seen
  - bits 7:5 = 0
- UART format: 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1; each bit is CLKS_PER_BIT cycles.
- Top FSM:
  - IDLE: on DHT_valid, or when the pending slot is full, go to CHECK.
  - CHECK: one cycle; latch the reading, update registers, build the status byte.
  - SEND: issue the byte at byte index 0..5 to uart_tx.
  - WAIT: wait for uart_tx ready. If index < 5, increment and go to SEND; otherwise go to IDLE.
- Pending slot, one deep:
  - DHT_valid outside IDLE stores the reading in the slot.
  - A second DHT_valid while the slot is full overwrites the slot and sets the overrun flag.
  - The overrun flag is reported in the next frame built from the slot, then cleared.
- DHT_valid arriving in the same cycle that WAIT returns to IDLE goes to the pending slot. It is then serviced from IDLE on the next cycle.

## Timing
- Reset values (asynchronous): TX=1, busy=0, all good_*=0, good_seen=0, stale=0, fail_cnt=0, pending empty, overrun=0, FSM in IDLE.
- Reset asserted mid-frame: TX goes to 1 immediately and the frame is abandoned. There is no resume after release.
- DHT_valid at cycle 0: CHECK at cycle 1. good_*, fail_cnt and stale are updated and visible from cycle 2. busy=1 from cycle 1.
- TX start bit begins at cycle 3.
- Byte handoff: uart_tx asserts ready for one cycle after the stop bit completes. The next start bit begins 2 cycles later.
- Frame length, cycle 3 to the last stop bit end: 60*CLKS_PER_BIT + 10 cycles.
- busy deasserts the cycle after the last ready. With the pending slot empty, a new DHT_valid is then accepted directly from IDLE.

## Structure
- Shared package dht_pkg holds:
  - SYNC_BYTE = 8'hA5
  - status bit indices
  - FRAME_LEN = 6
  - FSM state encoding: IDLE, CHECK, SEND, WAIT
- One sub-module, uart_tx.
  - Parameter: CLKS_PER_BIT.
  - Ports: CLK, RST, start, data[7:0], ready, TX.
  - Holds its own bit counter and baud counter.
  - start is accepted only when ready=1.

## Test plan
- Good reading, CLKS_PER_BIT=4 for speed:
  - Stimulus: hum_int=0x37, hum_float=0x00, tmp_int=0x18, tmp_float=0x05, parity=0x54.
  - Response: TX frame A5 37 00 18 05 10; good_tmp_int=0x18 at cycle 2; fail_cnt=0.
- Bad checksum after the good reading:
  - Stimulus: same bytes with parity=0x55.
  - Response: frame A5 37 00 18 05 11; good_* unchanged; fail_cnt=1.
- Sum wrap-around:
  - Stimulus: bytes FF, FF, 02, 00 with parity=0x00.
  - Response: judged good; frame A5 FF FF 02 00 10.
- Stale and saturation:
  - Stimulus: 3 readings with DHT_error=1.
  - Response: status of the third frame = 0x16; stale=1.
  - Stimulus: 15 more bad readings.
  - Response: fail_cnt holds at 15.
- Overrun:
  - Stimulus: three DHT_valid pulses during one frame.
  - Response: exactly two frames total. The second frame carries the third reading with status bit3=1. A following frame has bit3=0.
- Reset mid-frame:
  - Stimulus: assert RST during byte 2.
  - Response: TX=1 and busy=0 asynchronously; all outputs at reset values. The next DHT_valid produces a clean frame starting with 0xA5.

Source files
------------

// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11 reading reporter:
// frame constants, status bit positions, FSM encoding, reading bundle.
package dht_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN = 6;

    localparam int ST_MISMATCH  = 0;
    localparam int ST_DHT_ERR   = 1;
    localparam int ST_STALE     = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_GOOD_SEEN = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_SEND,
        S_WAIT
    } state_e;

    typedef struct packed {
        logic [7:0] hum_int;
        logic [7:0] hum_frac;
        logic [7:0] tmp_int;
        logic [7:0] tmp_frac;
        logic [7:0] parity;
    } reading_t;

    function automatic logic [7:0] sum8(reading_t r);
        return r.hum_int + r.hum_frac + r.tmp_int + r.tmp_frac;
    endfunction

endpackage

// File: rtl/dht_report_uart_tx.sv
// 8N1 UART transmitter, LSB first; ready is high whenever the line is idle,
// so it rises for the cycle right after the stop bit completes.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       TX
);

    localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic          busy_q;
    logic [9:0]    shift_q;
    logic [3:0]    bit_q;
    logic [CW-1:0] baud_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy_q  <= 1'b0;
            shift_q <= '1;
            bit_q   <= '0;
            baud_q  <= '0;
        end else if (!busy_q) begin
            if (start) begin
                busy_q  <= 1'b1;
                shift_q <= {1'b1, data, 1'b0};
                bit_q   <= '0;
                baud_q  <= '0;
            end
        end else if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 4'd9) begin
                busy_q <= 1'b0;
            end else begin
                bit_q   <= bit_q + 1'b1;
                shift_q <= {1'b1, shift_q[9:1]};
            end
        end else begin
            baud_q <= baud_q + 1'b1;
        end
    end

    assign ready = !busy_q;
    assign TX    = busy_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/dht_report.sv
// Checks DHT11 readings, holds the last good one, and reports each
// reading as a 6-byte UART status frame; one-deep pending slot.
module dht_report
    import dht_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int STALE_LIMIT = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DHT_valid,
    input  logic       DHT_error,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_float,
    input  logic [7:0] parity,
    output logic [7:0] good_hum_int,
    output logic [7:0] good_hum_float,
    output logic [7:0] good_tmp_int,
    output logic [7:0] good_tmp_float,
    output logic       good_seen,
    output logic       stale,
    output logic [3:0] fail_cnt,
    output logic       TX,
    output logic       busy
);

    localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [3:0] STALE_LIM    = 4'(STALE_LIMIT);
    localparam logic [2:0] LAST_IDX     = 3'(FRAME_LEN - 1);

    state_e     state_q, state_d;
    reading_t   in_rd, cur_q, slot_q, good_q;
    logic       cur_err_q, cur_ov_q;
    logic       slot_err_q, slot_full_q, slot_ov_q;
    logic       seen_q;
    logic [3:0] fail_q, fail_d;
    logic [7:0] status_q, status_d;
    logic [2:0] idx_q;
    logic       mismatch, good, seen_d;
    logic       u_start, u_ready;
    logic [7:0] u_data;

    assign in_rd = {hum_int, hum_float, tmp_int, tmp_float, parity};

    always_comb begin
        state_d = state_q;
        u_start = 1'b0;
        unique case (state_q)
            S_IDLE:  if (DHT_valid || slot_full_q) state_d = S_CHECK;
            S_CHECK: state_d = S_SEND;
            S_SEND: begin
                u_start = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (u_ready) state_d = (idx_q == LAST_IDX) ? S_IDLE : S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Status is built from the post-update register values.
    always_comb begin
        mismatch = sum8(cur_q) != cur_q.parity;
        good     = !mismatch && !cur_err_q;
        seen_d   = seen_q || good;
        fail_d   = good ? 4'd0 : (fail_q == 4'hF ? 4'hF : fail_q + 1'b1);
        status_d = '0;
        status_d[ST_MISMATCH]  = mismatch;
        status_d[ST_DHT_ERR]   = cur_err_q;
        status_d[ST_STALE]     = fail_d >= STALE_LIM;
        status_d[ST_OVERRUN]   = cur_ov_q;
        status_d[ST_GOOD_SEEN] = seen_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cur_q       <= '0;
            cur_err_q   <= 1'b0;
            cur_ov_q    <= 1'b0;
            slot_q      <= '0;
            slot_err_q  <= 1'b0;
            slot_full_q <= 1'b0;
            slot_ov_q   <= 1'b0;
            good_q      <= '0;
            seen_q      <= 1'b0;
            fail_q      <= '0;
            status_q    <= '0;
            idx_q       <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (slot_full_q) begin
                        cur_q       <= slot_q;
                        cur_err_q   <= slot_err_q;
                        cur_ov_q    <= slot_ov_q;
                        slot_ov_q   <= 1'b0;
                        slot_full_q <= DHT_valid;
                        if (DHT_valid) begin
                            slot_q     <= in_rd;
                            slot_err_q <= DHT_error;
                        end
                    end else if (DHT_valid) begin
                        cur_q     <= in_rd;
                        cur_err_q <= DHT_error;
                        cur_ov_q  <= 1'b0;
                    end
                end
                S_CHECK: begin
                    idx_q    <= '0;
                    fail_q   <= fail_d;
                    status_q <= status_d;
                    if (good) begin
                        good_q <= cur_q;
                        seen_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (u_ready && idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
            // Any reading arriving mid-frame parks in the slot.
            if (state_q != S_IDLE && DHT_valid) begin
                slot_q      <= in_rd;
                slot_err_q  <= DHT_error;
                slot_full_q <= 1'b1;
                slot_ov_q   <= slot_ov_q || slot_full_q;
            end
        end
    end

    always_comb begin
        unique case (idx_q)
            3'd0:    u_data = SYNC_BYTE;
            3'd1:    u_data = good_q.hum_int;
            3'd2:    u_data = good_q.hum_frac;
            3'd3:    u_data = good_q.tmp_int;
            3'd4:    u_data = good_q.tmp_frac;
            default: u_data = status_q;
        endcase
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .CLK  (CLK),
        .RST  (RST),
        .start(u_start),
        .data (u_data),
        .ready(u_ready),
        .TX   (TX)
    );

    assign good_hum_int   = good_q.hum_int;
    assign good_hum_float = good_q.hum_frac;
    assign good_tmp_int   = good_q.tmp_int;
    assign good_tmp_float = good_q.tmp_frac;
    assign good_seen      = seen_q;
    assign fail_cnt       = fail_q;
    assign stale          = fail_q >= STALE_LIM;
    assign busy           = state_q != S_IDLE;

endmodule

// File: tb/tb_dht_report.sv
// Bench for dht_report: reading-level model, UART frame decoder,
// and directed scenarios with hand-computed literals.
module tb_dht_report;

    localparam int C = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       DHT_valid = 1'b0;
    logic       DHT_error = 1'b0;
    logic [7:0] hum_int = '0, hum_float = '0, tmp_int = '0, tmp_float = '0, parity = '0;
    logic [7:0] good_hum_int, good_hum_float, good_tmp_int, good_tmp_float;
    logic       good_seen, stale, TX, busy;
    logic [3:0] fail_cnt;

    dht_report #(.CLK_HZ(4), .BAUD(1), .STALE_LIMIT(3)) dut (
        .CLK(CLK), .RST(RST), .DHT_valid(DHT_valid), .DHT_error(DHT_error),
        .hum_int(hum_int), .hum_float(hum_float), .tmp_int(tmp_int),
        .tmp_float(tmp_float), .parity(parity),
        .good_hum_int(good_hum_int), .good_hum_float(good_hum_float),
        .good_tmp_int(good_tmp_int), .good_tmp_float(good_tmp_float),
        .good_seen(good_seen), .stale(stale), .fail_cnt(fail_cnt),
        .TX(TX), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reading-level model: what the registers hold and what each frame says.
    logic [7:0] m_hi = 0, m_hf = 0, m_ti = 0, m_tf = 0;
    logic       m_seen = 0;
    int         m_fail = 0;
    logic [7:0] exp_q[$];

    function automatic void model_reset();
        m_hi = 0; m_hf = 0; m_ti = 0; m_tf = 0;
        m_seen = 0; m_fail = 0;
        exp_q.delete();
    endfunction

    function automatic void model(input logic [7:0] a, b, c, d, p, input logic err, input logic ov);
        int   s;
        logic mism;
        logic [7:0] st;
        s = int'(a) + int'(b) + int'(c) + int'(d);
        mism = (s % 256) != int'(p);
        if (!mism && !err) begin
            m_hi = a; m_hf = b; m_ti = c; m_tf = d;
            m_seen = 1; m_fail = 0;
        end else if (m_fail < 15) begin
            m_fail++;
        end
        st = 8'(mism) | (8'(err) << 1) | (8'(m_fail >= 3) << 2)
           | (8'(ov) << 3) | (8'(m_seen) << 4);
        exp_q.push_back(8'hA5);
        exp_q.push_back(m_hi);
        exp_q.push_back(m_hf);
        exp_q.push_back(m_ti);
        exp_q.push_back(m_tf);
        exp_q.push_back(st);
    endfunction

    // Compare process: UART decode against expected bytes, plus
    // register outputs whenever the design has settled.
    bit         rx_act = 0;
    int         rx_cnt_c = 0;
    logic [7:0] rx_sh;
    int         rx_cnt = 0;
    logic [7:0] last_rx = 0;
    logic [7:0] rx_log[$];

    always @(negedge CLK) begin
        logic [7:0] e;
        logic       m_st;
        int k;
        if (!RST) begin
            rx_act = 0;
        end else begin
            if (!rx_act) begin
                if (TX == 1'b0) begin
                    rx_act = 1;
                    rx_cnt_c = 0;
                end
            end else begin
                rx_cnt_c++;
                if (rx_cnt_c % C == C / 2) begin
                    k = rx_cnt_c / C;
                    if (k >= 1 && k <= 8) begin
                        rx_sh[k-1] = TX;
                    end else if (k == 9) begin
                        check("stop_bit", TX, 1'b1);
                        if (exp_q.size() == 0) begin
                            check("unexpected_byte", rx_sh, 8'hXX);
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_byte", rx_sh, e);
                        end
                        last_rx = rx_sh;
                        rx_log.push_back(rx_sh);
                        rx_cnt++;
                        rx_act = 0;
                    end
                end
            end
            if (!busy && !DHT_valid && exp_q.size() == 0) begin
                m_st = m_fail >= 3;
                check("idle_regs",
                      {good_hum_int, good_hum_float, good_tmp_int, good_tmp_float,
                       good_seen, stale, fail_cnt, TX},
                      {m_hi, m_hf, m_ti, m_tf, m_seen, m_st, 4'(m_fail), 1'b1});
            end
        end
    end

    int c0 = 0;

    task automatic pulse(input logic [7:0] a, b, c, d, p, input logic err,
                         input bit mdl, input logic ov);
        @(posedge CLK); #1;
        hum_int = a; hum_float = b; tmp_int = c; tmp_float = d; parity = p;
        DHT_error = err;
        DHT_valid = 1'b1;
        c0 = cyc;
        if (mdl) model(a, b, c, d, p, err, ov);
        @(posedge CLK); #1;
        DHT_valid = 1'b0;
        DHT_error = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        check("idle_timeout", 64'(n < 5000), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int base;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outs",
              {TX, busy, good_hum_int, good_hum_float, good_tmp_int, good_tmp_float,
               good_seen, stale, fail_cnt},
              {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0});
        @(posedge CLK); #1;
        RST = 1'b1;

        // Good reading with latency checks
        pulse(8'h37, 8'h00, 8'h18, 8'h05, 8'h54, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        check("busy_cyc1", busy, 1'b1);
        check("tmp_cyc1", good_tmp_int, 8'h00);
        @(negedge CLK);
        check("tmp_cyc2", good_tmp_int, 8'h18);
        check("fail_cyc2", fail_cnt, 4'd0);
        n = 0;
        while (TX !== 1'b0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("start_bit_cycle", 64'(cyc - c0), 64'd3);
        t0 = cyc;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("frame_len", 64'(cyc - t0), 64'(60 * C + 11));
        wait_idle();
        check("t1_status", last_rx, 8'h10);

        // Bad checksum
        pulse(8'h37, 8'h00, 8'h18, 8'h05, 8'h55, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check("t2_status", last_rx, 8'h11);
        check("t2_fail", fail_cnt, 4'd1);
        check("t2_hold", good_tmp_int, 8'h18);

        // Sum wrap-around
        pulse(8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check("t3_status", last_rx, 8'h10);
        check("t3_hum", good_hum_float, 8'hFF);

        // Stale
        for (int i = 0; i < 3; i++) begin
            pulse(8'h37, 8'h00, 8'h18, 8'h05, 8'h54, 1'b1, 1'b1, 1'b0);
            wait_idle();
        end
        check("t4_status", last_rx, 8'h16);
        check("t4_stale", stale, 1'b1);
        check("t4_fail", fail_cnt, 4'd3);

        // Saturation
        for (int i = 0; i < 15; i++) begin
            pulse(8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
            wait_idle();
        end
        check("t5_sat", fail_cnt, 4'd15);
        check("t5_hum", good_hum_int, 8'hFF);

        // Overrun
        base = rx_cnt;
        pulse(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 1'b0, 1'b1, 1'b0);
        repeat (20) @(posedge CLK);
        pulse(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A, 1'b0, 1'b0, 1'b0);
        repeat (20) @(posedge CLK);
        pulse(8'h10, 8'h20, 8'h30, 8'h40, 8'hA0, 1'b0, 1'b1, 1'b1);
        wait_idle();
        repeat (5) @(negedge CLK);
        check("t6_frames", 64'(rx_cnt - base), 64'd12);
        check("t6_status", last_rx, 8'h18);
        check("t6_hum", good_hum_int, 8'h10);
        pulse(8'h20, 8'h01, 8'h19, 8'h02, 8'h3C, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check("t6_next_status", last_rx, 8'h10);

        // Reset mid-frame
        base = rx_cnt;
        pulse(8'h37, 8'h00, 8'h18, 8'h05, 8'h54, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (rx_cnt < base + 2 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        repeat (10) @(negedge CLK);
        #2;
        RST = 1'b0;
        model_reset();
        #1;
        check("rst_async",
              {TX, busy, good_hum_int, good_hum_float, good_tmp_int, good_tmp_float,
               good_seen, stale, fail_cnt},
              {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0});
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        base = rx_cnt;
        pulse(8'h37, 8'h00, 8'h18, 8'h05, 8'h54, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check("rst_frame_len", 64'(rx_cnt - base), 64'd6);
        if (rx_cnt > base) check("rst_sync", rx_log[base], 8'hA5);
        check("rst_status", last_rx, 8'h10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
